// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Eight-digit multiplexed seven-segment display driver for a common-anode
// board. A 32-bit value (eight hex nibbles), a decimal-point mask and a
// leading-zero blanking enable are captured into shadow registers on
// Data_Valid. The digits are then time-multiplexed, and each digit is shown
// for ScanDivider clock cycles.
//
// Parameters:
//   ScanDivider      clock cycles per digit slot (>= 1)
//   NrOfBits         width of the scan counter; must hold ScanDivider-1
//
// Ports:
//   FPGA_GlobalClock  in   sole clock, rising edge
//   FPGA_GlobalReset  in   asynchronous active-high reset
//   Data_In[31:0]     in   display value, nibble i on digit i (digit 0 rightmost)
//   Data_Valid        in   capture strobe for Data_In / DP_Mask / Blank_En
//   DP_Mask[7:0]      in   bit i lights the decimal point of digit i
//   Blank_En          in   1 = blank leading zero digits
//   Seg[7:0]          out  active-low segments, bit0 = a .. bit6 = g, bit7 = dp
//   NA[7:0]           out  active-low digit enables, bit i = digit i
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int ScanDivider = 50000,
    parameter int NrOfBits    = 32
) (
    input  logic        FPGA_GlobalClock,
    input  logic        FPGA_GlobalReset,
    input  logic [31:0] Data_In,
    input  logic        Data_Valid,
    input  logic [7:0]  DP_Mask,
    input  logic        Blank_En,
    output logic [7:0]  Seg,
    output logic [7:0]  NA
);

    localparam logic [NrOfBits-1:0] LastCount = NrOfBits'(ScanDivider - 1);

    logic [NrOfBits-1:0] count_q, count_d;
    logic [2:0]          idx_q, idx_d;
    logic [31:0]         disp_q, disp_d;
    logic [7:0]          dp_q, dp_d;
    logic                blank_q, blank_d;
    logic [7:0]          seg_q, seg_d;
    logic [7:0]          na_q, na_d;

    logic                tick;
    logic [3:0]          nibble;
    logic [6:0]          pattern;     // active-high gfedcba
    logic [7:0]          upper_zero;  // bit i: nibbles i..7 of disp_q are all zero
    logic                blank_now;

    // -----------------------------------------------------------------------
    // Scan counter and digit index
    // -----------------------------------------------------------------------
    always_comb begin
        tick    = (count_q == LastCount);
        count_d = tick ? '0 : count_q + NrOfBits'(1);
        idx_d   = tick ? idx_q + 3'd1 : idx_q;
    end

    // -----------------------------------------------------------------------
    // Shadow registers
    // -----------------------------------------------------------------------
    always_comb begin
        disp_d  = disp_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        if (Data_Valid) begin
            disp_d  = Data_In;
            dp_d    = DP_Mask;
            blank_d = Blank_En;
        end
    end

    // -----------------------------------------------------------------------
    // Output decode, built from the register values before the edge
    // -----------------------------------------------------------------------
    always_comb begin
        nibble = disp_q[{idx_q, 2'b00} +: 4];
        case (nibble)
            4'h0:    pattern = 7'h3F;
            4'h1:    pattern = 7'h06;
            4'h2:    pattern = 7'h5B;
            4'h3:    pattern = 7'h4F;
            4'h4:    pattern = 7'h66;
            4'h5:    pattern = 7'h6D;
            4'h6:    pattern = 7'h7D;
            4'h7:    pattern = 7'h07;
            4'h8:    pattern = 7'h7F;
            4'h9:    pattern = 7'h6F;
            4'hA:    pattern = 7'h77;
            4'hB:    pattern = 7'h7C;
            4'hC:    pattern = 7'h39;
            4'hD:    pattern = 7'h5E;
            4'hE:    pattern = 7'h79;
            default: pattern = 7'h71;
        endcase
    end

    always_comb begin
        upper_zero = '0;
        for (int i = 0; i < 8; i++) begin
            upper_zero[i] = (disp_q >> (4 * i)) == 32'd0;
        end
        // Digit 0 is never blanked so a zero value still shows a single '0'.
        blank_now = blank_q && (idx_q != 3'd0) && upper_zero[idx_q];
    end

    always_comb begin
        if (blank_now) begin
            seg_d = 8'hFF;
            na_d  = 8'hFF;
        end else begin
            seg_d = {~dp_q[idx_q], ~pattern};
            na_d  = ~(8'd1 << idx_q);
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge FPGA_GlobalClock or posedge FPGA_GlobalReset) begin
        if (FPGA_GlobalReset) begin
            count_q <= '0;
            idx_q   <= 3'd0;
            disp_q  <= 32'd0;
            dp_q    <= 8'd0;
            blank_q <= 1'b0;
            seg_q   <= 8'hFF;
            na_q    <= 8'hFF;
        end else begin
            count_q <= count_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            dp_q    <= dp_d;
            blank_q <= blank_d;
            seg_q   <= seg_d;
            na_q    <= na_d;
        end
    end

    assign Seg = seg_q;
    assign NA  = na_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // stimulus
  logic [31:0] data;
  logic        dv;
  logic [7:0]  dpm;
  logic        blank;

  logic [7:0]  seg4, na4, seg1, na1;

  seg7_scan_driver #(.ScanDivider(4), .NrOfBits(4)) u_dut4 (
    .FPGA_GlobalClock (clk),
    .FPGA_GlobalReset (rst),
    .Data_In          (data),
    .Data_Valid       (dv),
    .DP_Mask          (dpm),
    .Blank_En         (blank),
    .Seg              (seg4),
    .NA               (na4)
  );

  seg7_scan_driver #(.ScanDivider(1), .NrOfBits(1)) u_dut1 (
    .FPGA_GlobalClock (clk),
    .FPGA_GlobalReset (rst),
    .Data_In          (data),
    .Data_Valid       (dv),
    .DP_Mask          (dpm),
    .Blank_En         (blank),
    .Seg              (seg1),
    .NA               (na1)
  );

  // counters
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: displayed digit is a function of edges since reset
  localparam logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [31:0] m_disp;
  logic [7:0]  m_dp;
  logic        m_blank;
  int          n_edges;
  logic [15:0] exp_q4[$];
  logic [15:0] exp_q1[$];

  // returns {NA, Seg} for digit d
  function automatic logic [15:0] model_out(input logic [31:0] v, input logic [7:0] dp,
                                            input logic b, input int d);
    logic [31:0] upper;
    logic [3:0]  nib;
    upper = v >> (4 * d);
    nib   = upper[3:0];
    if (b && d > 0 && upper == 32'd0) return 16'hFFFF;
    return {~(8'd1 << d), ~dp[d], ~PAT[nib]};
  endfunction

  // one clock: predict at the edge, compare at the following negedge
  task automatic step();
    logic [15:0] e4, e1;
    @(posedge clk);
    exp_q4.push_back(model_out(m_disp, m_dp, m_blank, (n_edges / 4) % 8));
    exp_q1.push_back(model_out(m_disp, m_dp, m_blank, n_edges % 8));
    if (dv) begin
      m_disp  = data;
      m_dp    = dpm;
      m_blank = blank;
    end
    n_edges++;
    @(negedge clk);
    e4 = exp_q4.pop_front();
    e1 = exp_q1.pop_front();
    check_eq("na_div4",  na4,  e4[15:8]);
    check_eq("seg_div4", seg4, e4[7:0]);
    check_eq("na_div1",  na1,  e1[15:8]);
    check_eq("seg_div1", seg1, e1[7:0]);
  endtask

  // called at a negedge; asserts reset between edges and releases at a negedge
  task automatic pulse_reset(input int cycles);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_na4",  na4,  8'hFF);
    check_eq("rst_seg4", seg4, 8'hFF);
    check_eq("rst_na1",  na1,  8'hFF);
    check_eq("rst_seg1", seg1, 8'hFF);
    repeat (cycles) @(negedge clk);
    rst     = 1'b0;
    m_disp  = 32'd0;
    m_dp    = 8'd0;
    m_blank = 1'b0;
    n_edges = 0;
  endtask

  task automatic load(input logic [31:0] v, input logic [7:0] m, input logic b);
    data  = v;
    dpm   = m;
    blank = b;
    dv    = 1'b1;
    step();
    dv    = 1'b0;
  endtask

  initial begin
    rst     = 1'b0;
    data    = 32'd0;
    dv      = 1'b0;
    dpm     = 8'd0;
    blank   = 1'b0;
    m_disp  = 32'd0;
    m_dp    = 8'd0;
    m_blank = 1'b0;
    n_edges = 0;
    @(negedge clk);

    // reset and first edge
    pulse_reset(2);
    step();
    check_eq("first_na",  na4,  8'hFE);
    check_eq("first_seg", seg4, 8'hC0);
    repeat (5) step();

    // full scan of 0x12345678
    load(32'h1234_5678, 8'h00, 1'b0);
    repeat (40) step();

    // leading-zero blanking
    load(32'h0000_0A30, 8'h00, 1'b1);
    repeat (40) step();
    load(32'h0000_0000, 8'h00, 1'b1);
    repeat (40) step();

    // decimal point on digit 0
    load(32'h0000_0000, 8'h01, 1'b0);
    repeat (40) step();

    // load coinciding with a tick on the divide-by-1 instance
    load(32'hFFFF_FFFF, 8'h00, 1'b0);
    step();
    check_eq("simul_seg1", seg1, 8'h8E);
    repeat (10) step();

    // reset in the middle of the scan (digit 5 on the divide-by-4 instance)
    pulse_reset(1);
    load(32'h8765_4321, 8'hA5, 1'b0);
    while (n_edges < 21) step();
    pulse_reset(3);
    step();
    check_eq("midrst_na",  na4,  8'hFE);
    check_eq("midrst_seg", seg4, 8'hC0);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      dv    = ($urandom_range(0, 7) == 0);
      data  = $urandom >> (4 * $urandom_range(0, 8));
      dpm   = 8'($urandom);
      blank = 1'($urandom_range(0, 1));
      step();
      if ($urandom_range(0, 399) == 0) pulse_reset($urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Eight-digit multiplexed seven-segment display driver sitting directly downstream of the CPU core and driving the board's `Seg`/`NA` pins. It captures a 32-bit value (eight hex nibbles) plus a decimal-point mask on a strobe, then time-multiplexes the digits at a rate set by a programmable scan divider. Outputs are registered and active-low, matching the board's common-anode display.

## Interface
- `ScanDivider`, 50000, clock cycles per digit slot (≥1); 50 MHz clock gives 1 kHz per digit.
- `NrOfBits`, 32, width of the scan divider counter; must hold `ScanDivider-1`.
- `FPGA_GlobalClock`  in  1  sole clock, all state on rising edge.
- `FPGA_GlobalReset`  in  1  asynchronous, active-high reset.
- `Data_In`  in  32  display value; nibble i shown on digit i, digit 0 rightmost.
- `Data_Valid`  in  1  capture strobe for `Data_In`, `DP_Mask`, `Blank_En`.
- `DP_Mask`  in  8  bit i = 1 lights decimal point on digit i.
- `Blank_En`  in  1  1 = blank leading zero digits.
- `Seg`  out  8  active-low segments; bit0 = a … bit6 = g, bit7 = dp.
- `NA`  out  8  active-low digit enables; bit i = digit i.

## Operation
- Shadow registers: `disp_q[31:0]`, `dp_q[7:0]`, `blank_q` load on any edge with `Data_Valid = 1`; otherwise hold. Reset value 0. `Data_Valid` held high captures every cycle.
- Scan counter: counts 0 … `ScanDivider-1`, wraps to 0; `tick` = (count == `ScanDivider-1`). `ScanDivider = 1` → tick every cycle.
- Digit index `idx[2:0]`: increments on tick, wraps 7 → 0. Reset 0.
- Hex decode (active-high gfedcba): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. `Seg[6:0]` = inverted pattern; `Seg[7]` = ~`dp_q[idx]`.
- Leading-zero blanking (when `blank_q = 1`): digit i blanked iff i > 0 and nibbles i…7 of `disp_q` are all zero. Blanked digit: `Seg = 8'hFF`, `NA = 8'hFF` (DP suppressed too). Digit 0 never blanked; value 0 shows a single `0`.
- Output register: every edge, `NA` ← one-cold on `idx` (or FF if blanked), `Seg` ← decode of nibble `idx` of `disp_q`, using register values before the edge.
- Exactly one `NA` bit low at any time outside reset/blanking; never two.

## Timing
- Reset (async): immediately `Seg = 8'hFF`, `NA = 8'hFF`, counter 0, `idx` 0, shadows 0; no clock edge required. Reset asserted mid-scan behaves identically.
- First edge after reset release: `NA = 8'hFE`, `Seg = 8'hC0` (digit 0 showing `0`).
- Latency: `Data_Valid` at edge k → shadow updated at k → visible on `Seg` at edge k+1 if `idx` selects an affected digit; update never tears within a digit slot beyond that one-cycle edge.
- Index change at tick edge k → `NA` moves at edge k+1; each digit shown for exactly `ScanDivider` cycles; full frame = 8 × `ScanDivider` cycles.
- Simultaneous `Data_Valid` and tick: both take effect at the same edge; next output uses new index and new data.
- Counter wrap and `idx` wrap 7 → 0 produce no gap or extra cycle.

## Test plan
- Reset: `FPGA_GlobalReset` pulsed between clock edges → `Seg = FF`, `NA = FF` within the same cycle; first edge after release → `NA = FE`, `Seg = C0`.
- Scan: `ScanDivider = 4`, load `0x12345678`, `DP_Mask = 0`, `Blank_En = 0` → `NA` steps FE, FD, FB, F7, EF, DF, BF, 7F, FE, each held 4 cycles; digit 0 `Seg = 80`, digit 7 `Seg = F9`.
- Blanking: `Blank_En = 1`, load `0x00000A30` → digits 0–2 show `Seg = C0, B0, 88`; digits 3–7 slots give `Seg = FF`, `NA = FF`; load `0` → only digit 0, `Seg = C0`.
- Decimal point: load `0` with `DP_Mask = 01`, `Blank_En = 0` → digit 0 `Seg = 40`, digits 1–7 `Seg = C0`.
- Simultaneous update: `ScanDivider = 1`, pulse `Data_Valid` with `0xFFFFFFFF` on a tick edge → next output `Seg = 8E` on the new digit, no stale digit.
- Mid-scan reset: assert reset while `idx = 5` → outputs FF immediately; after release scan restarts at digit 0 with value 0.
